// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
// Shared definitions for the FIFO write-port arbiter:
//   DEFAULT_FIFO_WIDTH - default data width of the shared FIFO
//   ARB_BURST_LEN      - default maximum words per grant
//   arb_state_e        - arbiter FSM states
//   wrap_inc()         - modular increment used for round-robin rotation
// ---------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

  localparam int DEFAULT_FIFO_WIDTH = 16;
  localparam int ARB_BURST_LEN      = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BURST,
    ARB_STALL
  } arb_state_e;

  // value + 1, wrapping to 0 at modulus
  function automatic int wrap_inc(input int value, input int modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin priority encoder. Returns the first requester
// found when scanning upward from rr_ptr, wrapping at NUM_REQ-1 to 0.
// Ports:
//   req     in  NUM_REQ          request vector
//   rr_ptr  in  $clog2(NUM_REQ)  index with highest priority
//   winner  out $clog2(NUM_REQ)  selected index (0 when any_req is low)
//   any_req out 1                at least one request is present
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_req
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // cand[gi] is the requester index sitting gi places after rr_ptr
  logic [IDX_W-1:0]   cand [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    logic [IDX_W:0] wrapped;
    assign sum        = {1'b0, rr_ptr} + (IDX_W + 1)'(gi);
    assign wrapped    = sum - (IDX_W + 1)'(NUM_REQ);
    assign cand[gi]   = (sum >= (IDX_W + 1)'(NUM_REQ)) ? wrapped[IDX_W-1:0]
                                                       : sum[IDX_W-1:0];
    assign hit[gi]    = req[cand[gi]];
  end

  // Scan from the far end so the closest hit to rr_ptr is assigned last
  always_comb begin
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        winner = cand[k];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A grant holder keeps the port for up to BURST_LEN consecutive words. The
// arbiter never writes when the FIFO is full, or when it has one free slot
// and a write is already in flight. All outputs are registered.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req, req_data     per-producer request and word (slice i = word i)
//   gnt               one-hot: producer i's word was written this cycle
//   fifo_wr_en        FIFO write enable
//   fifo_data_in      FIFO write data
//   fifo_full         FIFO full
//   fifo_almostfull   FIFO has exactly one free slot
//   fifo_wr_ack       FIFO acknowledge, one cycle after an accepted write
//   fifo_overflow     FIFO overflow flag
//   owner             current grant holder index
//   busy              arbiter not idle
//   err_overflow      sticky: fifo_overflow observed
//   err_ack           sticky: write not acknowledged on the next cycle
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
  parameter int BURST_LEN  = ARB_BURST_LEN
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic                          err_overflow,
  output logic                          err_ack
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 4;

  arb_state_e             state_reg, state_next;
  logic [IDX_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]       owner_reg, owner_next;
  logic [CNT_W-1:0]       beat_cnt_reg, beat_cnt_next;
  logic [NUM_REQ-1:0]     gnt_reg, gnt_next;
  logic                   wr_en_reg, wr_en_next;
  logic [FIFO_WIDTH-1:0]  data_reg, data_next;
  logic                   busy_reg;
  logic                   wr_en_d_reg;
  logic                   err_overflow_reg;
  logic                   err_ack_reg;

  logic [FIFO_WIDTH-1:0]  word_arr [NUM_REQ];
  logic [IDX_W-1:0]       winner;
  logic                   any_req;
  logic                   can_wr;
  logic                   issue;
  logic [IDX_W-1:0]       sel;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign word_arr[gi] = req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr_reg),
    .winner  (winner),
    .any_req (any_req)
  );

  // A write registered last cycle lands on the next edge, so with one free
  // slot left that write already fills the FIFO.
  assign can_wr = !fifo_full && !(fifo_almostfull && wr_en_reg);

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    owner_next    = owner_reg;
    beat_cnt_next = beat_cnt_reg;
    gnt_next      = '0;
    wr_en_next    = 1'b0;
    data_next     = data_reg;
    issue         = 1'b0;
    sel           = owner_reg;

    case (state_reg)
      ARB_IDLE: begin
        if (any_req) begin
          owner_next    = winner;
          sel           = winner;
          beat_cnt_next = '0;
          if (can_wr) begin
            issue         = 1'b1;
            beat_cnt_next = CNT_W'(1);
            state_next    = ARB_BURST;
          end else begin
            state_next = ARB_STALL;
          end
        end
      end

      ARB_BURST: begin
        if (beat_cnt_reg == CNT_W'(BURST_LEN) || !req[owner_reg]) begin
          state_next  = ARB_IDLE;
          rr_ptr_next = IDX_W'(wrap_inc(int'(owner_reg), NUM_REQ));
        end else if (can_wr) begin
          issue         = 1'b1;
          beat_cnt_next = beat_cnt_reg + CNT_W'(1);
        end else begin
          state_next = ARB_STALL;
        end
      end

      ARB_STALL: begin
        // Only entered with beat_cnt below BURST_LEN, so no length check
        if (!req[owner_reg]) begin
          state_next  = ARB_IDLE;
          rr_ptr_next = IDX_W'(wrap_inc(int'(owner_reg), NUM_REQ));
        end else if (can_wr) begin
          issue         = 1'b1;
          beat_cnt_next = beat_cnt_reg + CNT_W'(1);
          state_next    = ARB_BURST;
        end
      end

      default: begin
        state_next = ARB_IDLE;
      end
    endcase

    if (issue) begin
      wr_en_next = 1'b1;
      gnt_next   = NUM_REQ'(1) << sel;
      data_next  = word_arr[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= ARB_IDLE;
      rr_ptr_reg       <= '0;
      owner_reg        <= '0;
      beat_cnt_reg     <= '0;
      gnt_reg          <= '0;
      wr_en_reg        <= 1'b0;
      data_reg         <= '0;
      busy_reg         <= 1'b0;
      wr_en_d_reg      <= 1'b0;
      err_overflow_reg <= 1'b0;
      err_ack_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      rr_ptr_reg       <= rr_ptr_next;
      owner_reg        <= owner_next;
      beat_cnt_reg     <= beat_cnt_next;
      gnt_reg          <= gnt_next;
      wr_en_reg        <= wr_en_next;
      data_reg         <= data_next;
      busy_reg         <= (state_next != ARB_IDLE);
      // wr_en_d_reg marks the edge at which the FIFO must present wr_ack
      wr_en_d_reg      <= wr_en_reg;
      err_overflow_reg <= err_overflow_reg | fifo_overflow;
      err_ack_reg      <= err_ack_reg | (wr_en_d_reg & ~fifo_wr_ack);
    end
  end

  assign gnt          = gnt_reg;
  assign fifo_wr_en   = wr_en_reg;
  assign fifo_data_in = data_reg;
  assign owner        = owner_reg;
  assign busy         = busy_reg;
  assign err_overflow = err_overflow_reg;
  assign err_ack      = err_ack_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed scenarios plus a randomized phase. A behavioural FIFO and
// producer queues surround the arbiter; a rule-level reference predicts the
// registered outputs each cycle, and end-to-end scoreboards check ordering.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int BL = 4;
  localparam int IW = $clog2(N);
  localparam int PCAP = 4096;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    gnt;
  logic            fifo_wr_en;
  logic [W-1:0]    fifo_data_in;
  logic            fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
  logic [IW-1:0]   owner;
  logic            busy, err_overflow, err_ack;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
    .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
    .owner(owner), .busy(busy), .err_overflow(err_overflow), .err_ack(err_ack)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // producers: word store with head/tail per producer
  logic [W-1:0] p_mem [N][PCAP];
  int           p_head [N];
  int           p_tail [N];
  bit           active [N];

  // behavioural FIFO
  logic [W-1:0] fifo_q [$];
  int           fifo_depth;
  bit           rd_on;
  int           rd_pct;
  bit           ack_kill;
  bit           ovf_inject;
  logic         ack_r, ovf_r;

  // scoreboards
  logic [W-1:0] wr_log [$];
  int           owner_log [$];
  int           cycle_log [$];

  // reference: holder (-1 style via mode), words in burst, pointer
  int           m_mode;     // 0 no holder, 1 writing, 2 waiting for room
  int           m_owner, m_cnt, m_ptr;
  bit           m_prev_wr, m_eack, m_eovf;
  logic [N-1:0] e_gnt;
  bit           e_wr;
  logic [W-1:0] e_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      p_mem[p][p_tail[p]] = W'($urandom);
      p_tail[p]++;
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += p_tail[i] - p_head[i];
    return s;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req[i] = active[i] && (p_head[i] < p_tail[i]);
      req_data[i*W +: W] = (p_head[i] < p_tail[i]) ? p_mem[i][p_head[i]] : '0;
    end
    fifo_full       = (fifo_q.size() >= fifo_depth);
    fifo_almostfull = (fifo_q.size() == fifo_depth - 1);
    fifo_wr_ack     = ack_r;
    fifo_overflow   = ovf_r;
  endtask

  task automatic step();
    logic         pre_wr, pre_full, pre_af, pre_ack, pre_ovf, pre_rst;
    logic [W-1:0] pre_data, w;
    logic [N-1:0] pre_req;
    logic [N*W-1:0] pre_rd;
    bit           can, want, found;
    int           cnt0;

    pre_wr = fifo_wr_en;  pre_data = fifo_data_in; pre_req = req;
    pre_rd = req_data;    pre_full = fifo_full;    pre_af = fifo_almostfull;
    pre_ack = fifo_wr_ack; pre_ovf = fifo_overflow; pre_rst = rst_n;

    @(posedge clk); #1;
    cyc++;

    // FIFO: pop then push, both judged on the occupancy before the edge
    cnt0 = fifo_q.size();
    if (rd_on && cnt0 > 0 && int'($urandom_range(99)) < rd_pct) begin
      w = fifo_q.pop_front();
      check("readback_expected", 64'(wr_log.size() > 0), 64'(1));
      if (wr_log.size() > 0) check("readback_order", 64'(w), 64'(wr_log.pop_front()));
    end
    if (pre_wr === 1'b1) check("write_while_full", 64'(cnt0 < fifo_depth), 64'(1));
    ack_r = (pre_wr === 1'b1) && (cnt0 < fifo_depth) && !ack_kill;
    ovf_r = ((pre_wr === 1'b1) && (cnt0 >= fifo_depth)) || ovf_inject;
    if ((pre_wr === 1'b1) && cnt0 < fifo_depth) fifo_q.push_back(pre_data);

    // reference model
    can   = !pre_full && !(pre_af && pre_wr);
    e_gnt = '0;
    e_wr  = 1'b0;
    want  = 1'b0;
    if (pre_rst !== 1'b1) begin
      m_mode = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; e_data = '0;
      m_eack = 0; m_eovf = 0; m_prev_wr = 0;
    end else begin
      if (m_prev_wr && pre_ack !== 1'b1) m_eack = 1;
      if (pre_ovf === 1'b1) m_eovf = 1;
      m_prev_wr = (pre_wr === 1'b1);
      if (m_mode == 0) begin
        if (pre_req != 0) begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (!found && pre_req[c]) begin m_owner = c; found = 1; end
          end
          m_cnt = 0;
          want  = 1;
        end
      end else if (m_cnt == BL || !pre_req[m_owner]) begin
        m_mode = 0;
        m_ptr  = (m_owner + 1) % N;
      end else begin
        want = 1;
      end
      if (want) begin
        if (can) begin
          e_wr   = 1'b1;
          e_gnt  = N'(1) << m_owner;
          e_data = pre_rd[m_owner*W +: W];
          m_cnt++;
          m_mode = 1;
        end else begin
          m_mode = 2;
        end
      end
    end

    check("gnt",          64'(gnt),          64'(e_gnt));
    check("fifo_wr_en",   64'(fifo_wr_en),   64'(e_wr));
    check("fifo_data_in", 64'(fifo_data_in), 64'(e_data));
    check("owner",        64'(owner),        64'(m_owner));
    check("busy",         64'(busy),         64'(m_mode != 0));
    check("err_ack",      64'(err_ack),      64'(m_eack));
    check("err_overflow", 64'(err_overflow), 64'(m_eovf));

    // producers retire the granted word
    for (int i = 0; i < N; i++) begin
      if (gnt[i] === 1'b1) begin
        check("gnt_has_word", 64'(p_head[i] < p_tail[i]), 64'(1));
        if (p_head[i] < p_tail[i]) begin
          check("gnt_data", 64'(fifo_data_in), 64'(p_mem[i][p_head[i]]));
          p_head[i]++;
        end
        wr_log.push_back(fifo_data_in);
        owner_log.push_back(i);
        cycle_log.push_back(cyc);
        $display("cyc %0d: gnt p%0d data=%h fifo_count=%0d", cyc, i, fifo_data_in, fifo_q.size());
      end
    end
    drive_inputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    rd_on = 1; rd_pct = 100;
    for (int i = 0; i < N; i++) active[i] = 1;
    drive_inputs();
    for (int t = 0; t < budget && (pending() > 0 || fifo_q.size() > 0 ||
         fifo_wr_en === 1'b1 || busy === 1'b1); t++) step();
    check("drain_pending", 64'(pending()), 64'(0));
    check("drain_fifo_empty", 64'(fifo_q.size()), 64'(0));
    check("drain_log_empty", 64'(wr_log.size()), 64'(0));
  endtask

  initial begin
    int g0, c0;
    rst_n = 1'b0; ack_r = 1'b0; ovf_r = 1'b0;
    fifo_depth = 64; rd_on = 1; rd_pct = 100; ack_kill = 0; ovf_inject = 0;
    for (int i = 0; i < N; i++) begin p_head[i] = 0; p_tail[i] = 0; active[i] = 0; end
    drive_inputs();

    // reset state
    step(); step();
    rst_n = 1'b1;
    check("reset_gnt", 64'(gnt), 64'(0));
    check("reset_wr_en", 64'(fifo_wr_en), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));

    // single producer, 8 words: two bursts of 4 separated by one idle cycle
    active[0] = 1; load(0, 8); drive_inputs();
    g0 = cycle_log.size(); c0 = cyc;
    for (int t = 0; t < 40 && (pending() > 0 || busy === 1'b1); t++) step();
    check("s1_words", 64'(cycle_log.size() - g0), 64'(8));
    if (cycle_log.size() - g0 >= 8) begin
      check("s1_latency", 64'(cycle_log[g0] - c0), 64'(1));
      for (int j = 1; j < 8; j++)
        check("s1_gap", 64'(cycle_log[g0+j] - cycle_log[g0+j-1]), 64'((j == 4) ? 2 : 1));
    end
    drain(50);

    // all four requesting: bursts to 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) begin active[i] = 1; load(i, 20); end
    drive_inputs();
    g0 = owner_log.size();
    for (int t = 0; t < 120 && owner_log.size() - g0 < 20; t++) step();
    check("s2_grant_count", 64'(owner_log.size() - g0 >= 20), 64'(1));
    if (owner_log.size() - g0 >= 20)
      for (int j = 0; j < 20; j++)
        check("s2_owner_order", 64'(owner_log[g0+j]), 64'((j / 4) % N));
    drain(300);

    // depth 8, no reads, producer 2 streaming: exactly 8 writes then stall
    fifo_depth = 8; rd_on = 0;
    for (int i = 0; i < N; i++) active[i] = (i == 2);
    load(2, 12); drive_inputs();
    g0 = owner_log.size();
    for (int t = 0; t < 40; t++) step();
    check("s3_writes", 64'(owner_log.size() - g0), 64'(8));
    check("s3_fifo_count", 64'(fifo_q.size()), 64'(8));
    check("s3_full", 64'(fifo_full), 64'(1));
    check("s3_stalled_busy", 64'(busy), 64'(1));
    check("s3_no_err_overflow", 64'(err_overflow), 64'(0));
    drain(100);

    // reset mid-burst at owner 3, beat 2
    fifo_depth = 64;
    for (int i = 0; i < N; i++) begin active[i] = 1; load(i, 12); end
    drive_inputs();
    for (int t = 0; t < 100 && !(m_mode == 1 && m_owner == 3 && m_cnt == 2); t++) step();
    check("s4_owner3", 64'(owner), 64'(3));
    do_reset();
    check("s4_rst_gnt", 64'(gnt), 64'(0));
    check("s4_rst_wr_en", 64'(fifo_wr_en), 64'(0));
    check("s4_rst_data", 64'(fifo_data_in), 64'(0));
    check("s4_rst_owner", 64'(owner), 64'(0));
    check("s4_rst_busy", 64'(busy), 64'(0));
    g0 = owner_log.size();
    for (int t = 0; t < 10 && owner_log.size() == g0; t++) step();
    check("s4_restart_seen", 64'(owner_log.size() > g0), 64'(1));
    if (owner_log.size() > g0) check("s4_restart_owner", 64'(owner_log[g0]), 64'(0));
    drain(300);

    // missing write acknowledge sets sticky err_ack
    for (int i = 0; i < N; i++) active[i] = (i == 1);
    load(1, 3); drive_inputs();
    for (int t = 0; t < 10 && fifo_wr_en !== 1'b1; t++) step();
    check("s5_write_seen", 64'(fifo_wr_en), 64'(1));
    ack_kill = 1; step(); ack_kill = 0;
    step();
    check("s5_err_ack", 64'(err_ack), 64'(1));
    repeat (4) step();
    check("s5_err_ack_sticky", 64'(err_ack), 64'(1));
    drain(50);
    do_reset();
    check("s5_err_ack_cleared", 64'(err_ack), 64'(0));

    // overflow flag from the FIFO sets sticky err_overflow
    ovf_inject = 1; step(); ovf_inject = 0;
    step();
    check("s6_err_overflow", 64'(err_overflow), 64'(1));
    repeat (3) step();
    check("s6_err_overflow_sticky", 64'(err_overflow), 64'(1));
    do_reset();
    check("s6_err_overflow_cleared", 64'(err_overflow), 64'(0));

    // randomized traffic against a small, slowly drained FIFO
    fifo_depth = 8; rd_on = 1; rd_pct = 50;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (p_tail[i] - p_head[i] < 6 && $urandom_range(99) < 25) load(i, 1);
        if ($urandom_range(99) < 4) active[i] = !active[i];
      end
      drive_inputs();
      step();
    end
    drain(400);
    check("final_no_err_overflow", 64'(err_overflow), 64'(0));
    check("final_no_err_ack", 64'(err_ack), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
